// File: rtl/dtw_score_cell.sv
// ---------------------------------------------------------------------------
// dtw_score_cell
//
// One cell of a dynamic-time-warping score lattice, located at column TINDEX
// and row RINDEX. When the compute strobe addresses this cell while it is
// empty, it selects the cheapest valid neighbour, adds the local distance
// with saturation, and stores the score and a back-pointer. During traceback
// it drives its result word onto a shared OR-bus and pulses the traceback
// enable of exactly one neighbour, or flags itself as the path origin.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   i_clr                  synchronous clear back to EMPTY (between utterances)
//   i_valid                compute strobe for the pair on i_tindex/i_rindex
//   i_tindex, i_rindex     lattice position being computed
//   i_dlocal               local distance d(i,j)
//   i_s_diag/up/left       neighbour scores
//   i_v_diag/up/left       neighbour score valid (low = outside the lattice)
//   i_tb_en                traceback select for this cell
//   o_score, o_score_vld   stored score; high while the cell holds data
//   o_data, o_data_oe      {path, TINDEX, RINDEX, score}; zero when not selected
//   o_tb_diag/up/left      one-cycle traceback pulse to the chosen neighbour
//   o_tb_done              one-cycle pulse: this cell is the path origin
//   o_sat                  sticky saturation flag
// ---------------------------------------------------------------------------
module dtw_score_cell #(
  parameter int unsigned   DW     = 16,
  parameter int unsigned   IW     = 5,
  parameter logic [IW-1:0] TINDEX = {IW{1'b1}},
  parameter logic [IW-1:0] RINDEX = {IW{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_valid,
  input  logic [IW-1:0]        i_tindex,
  input  logic [IW-1:0]        i_rindex,
  input  logic [DW-1:0]        i_dlocal,
  input  logic [DW-1:0]        i_s_diag,
  input  logic [DW-1:0]        i_s_up,
  input  logic [DW-1:0]        i_s_left,
  input  logic                 i_v_diag,
  input  logic                 i_v_up,
  input  logic                 i_v_left,
  input  logic                 i_tb_en,
  output logic [DW-1:0]        o_score,
  output logic                 o_score_vld,
  output logic [DW+2*IW+1:0]   o_data,
  output logic                 o_data_oe,
  output logic                 o_tb_diag,
  output logic                 o_tb_up,
  output logic                 o_tb_left,
  output logic                 o_tb_done,
  output logic                 o_sat
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_VALID  = 2'b01,
    ST_TRACED = 2'b10
  } state_t;

  localparam logic [1:0]    PATH_DIAG   = 2'b11;
  localparam logic [1:0]    PATH_UP     = 2'b10;
  localparam logic [1:0]    PATH_LEFT   = 2'b01;
  localparam logic [1:0]    PATH_ORIGIN = 2'b00;
  localparam logic [IW-1:0] IDX_UNUSED  = {IW{1'b1}};
  // A cell parked at the all-ones index is unused and must never capture.
  localparam logic          CELL_USED   = (TINDEX != IDX_UNUSED) && (RINDEX != IDX_UNUSED);

  state_t        r_state;
  logic [DW-1:0] r_score;
  logic [1:0]    r_path;
  logic          r_sat;
  logic [3:0]    r_pulse;      // {diag, up, left, done}

  state_t        w_state_nxt;
  logic [DW-1:0] w_score_nxt;
  logic [1:0]    w_path_nxt;
  logic          w_sat_nxt;
  logic [3:0]    w_pulse_nxt;

  logic          w_have;
  logic [DW-1:0] w_best;
  logic [1:0]    w_best_path;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_cap_score;
  logic          w_cap_sat;
  logic          w_capture;

  assign w_capture = CELL_USED && (r_state == ST_EMPTY) && i_valid &&
                     (i_tindex == TINDEX) && (i_rindex == RINDEX);

  // Minimum over valid neighbours; strict less-than keeps diag > up > left on ties.
  always_comb begin
    w_have      = 1'b0;
    w_best      = {DW{1'b0}};
    w_best_path = PATH_ORIGIN;
    if (i_v_diag) begin
      w_have      = 1'b1;
      w_best      = i_s_diag;
      w_best_path = PATH_DIAG;
    end else begin
      w_have      = 1'b0;
    end
    if (i_v_up && (!w_have || (i_s_up < w_best))) begin
      w_have      = 1'b1;
      w_best      = i_s_up;
      w_best_path = PATH_UP;
    end else begin
      w_have      = w_have;
    end
    if (i_v_left && (!w_have || (i_s_left < w_best))) begin
      w_have      = 1'b1;
      w_best      = i_s_left;
      w_best_path = PATH_LEFT;
    end else begin
      w_have      = w_have;
    end
  end

  assign w_sum = {1'b0, w_best} + {1'b0, i_dlocal};

  // Captured score: local distance alone at an origin, else saturating sum.
  always_comb begin
    w_cap_score = i_dlocal;
    w_cap_sat   = 1'b0;
    if (!w_have) begin
      w_cap_score = i_dlocal;
      w_cap_sat   = 1'b0;
    end else if (w_sum[DW]) begin
      w_cap_score = {DW{1'b1}};
      w_cap_sat   = 1'b1;
    end else begin
      w_cap_score = w_sum[DW-1:0];
      w_cap_sat   = 1'b0;
    end
  end

  // Next-state and next-output logic for the cell state machine.
  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_path_nxt  = r_path;
    w_sat_nxt   = r_sat;
    w_pulse_nxt = 4'b0000;
    case (r_state)
      ST_EMPTY: begin
        if (w_capture) begin
          w_state_nxt = ST_VALID;
          w_score_nxt = w_cap_score;
          w_path_nxt  = w_best_path;
          w_sat_nxt   = r_sat | w_cap_sat;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_VALID: begin
        if (i_tb_en) begin
          w_state_nxt = ST_TRACED;
          case (r_path)
            PATH_DIAG: w_pulse_nxt = 4'b1000;
            PATH_UP:   w_pulse_nxt = 4'b0100;
            PATH_LEFT: w_pulse_nxt = 4'b0010;
            default:   w_pulse_nxt = 4'b0001;
          endcase
        end else begin
          w_state_nxt = ST_VALID;
        end
      end
      ST_TRACED: begin
        w_state_nxt = ST_TRACED;
      end
      default: begin
        // Illegal encoding: fall back to a clean empty cell.
        w_state_nxt = ST_EMPTY;
        w_score_nxt = {DW{1'b0}};
        w_path_nxt  = PATH_ORIGIN;
        w_sat_nxt   = 1'b0;
      end
    endcase
  end

  // State, score, back-pointer, sticky flag and pulse registers.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_state <= ST_EMPTY;
      r_score <= {DW{1'b0}};
      r_path  <= PATH_ORIGIN;
      r_sat   <= 1'b0;
      r_pulse <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_score <= w_score_nxt;
      r_path  <= w_path_nxt;
      r_sat   <= w_sat_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  assign o_score     = r_score;
  assign o_score_vld = (r_state != ST_EMPTY);
  assign o_sat       = r_sat;
  assign o_tb_diag   = r_pulse[3];
  assign o_tb_up     = r_pulse[2];
  assign o_tb_left   = r_pulse[1];
  assign o_tb_done   = r_pulse[0];

  // OR-bus drive: zero unless this cell is selected and holds data.
  assign o_data_oe = i_tb_en && (r_state != ST_EMPTY);
  assign o_data    = o_data_oe ? {r_path, TINDEX, RINDEX, r_score}
                               : {(DW+2*IW+2){1'b0}};

endmodule

// File: tb/tb_dtw_score_cell.sv
// ---------------------------------------------------------------------------
// tb_dtw_score_cell
//
// Three cells share one compute bus: the origin (0,0), an interior cell (3,2)
// and an unused cell (31,31). Stimulus pushes the expected observation
// of each cell for the current cycle into a queue; a monitor on the falling
// edge pops and compares every entry stamped with that cycle.
// ---------------------------------------------------------------------------
module tb_dtw_score_cell;

  localparam int DW = 16;
  localparam int IW = 5;
  localparam int XW = DW + 2*IW + 2;

  typedef struct packed {
    logic [XW-1:0] data;
    logic          oe;
    logic [3:0]    pul;    // {diag, up, left, done}
    logic [DW-1:0] score;
    logic          vld;
    logic          sat;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst, clr, valid;
  logic [IW-1:0] tidx, ridx;
  logic [DW-1:0] dlocal, s_diag, s_up, s_left;
  logic          v_diag, v_up, v_left;
  logic          tb_en0, tb_en1, tb_en2;

  logic [DW-1:0] score0, score1, score2;
  logic          vld0, vld1, vld2;
  logic [XW-1:0] data0, data1, data2;
  logic          oe0, oe1, oe2;
  logic          td0, tu0, tl0, tn0, td1, tu1, tl1, tn1, td2, tu2, tl2, tn2;
  logic          sat0, sat1, sat2;

  always #5 clk = ~clk;

  dtw_score_cell #(.DW(DW), .IW(IW), .TINDEX(5'd0), .RINDEX(5'd0)) u_origin (
    .clk(clk), .rst(rst), .i_clr(clr), .i_valid(valid), .i_tindex(tidx), .i_rindex(ridx),
    .i_dlocal(dlocal), .i_s_diag(s_diag), .i_s_up(s_up), .i_s_left(s_left),
    .i_v_diag(v_diag), .i_v_up(v_up), .i_v_left(v_left), .i_tb_en(tb_en0),
    .o_score(score0), .o_score_vld(vld0), .o_data(data0), .o_data_oe(oe0),
    .o_tb_diag(td0), .o_tb_up(tu0), .o_tb_left(tl0), .o_tb_done(tn0), .o_sat(sat0));

  dtw_score_cell #(.DW(DW), .IW(IW), .TINDEX(5'd3), .RINDEX(5'd2)) u_cell32 (
    .clk(clk), .rst(rst), .i_clr(clr), .i_valid(valid), .i_tindex(tidx), .i_rindex(ridx),
    .i_dlocal(dlocal), .i_s_diag(s_diag), .i_s_up(s_up), .i_s_left(s_left),
    .i_v_diag(v_diag), .i_v_up(v_up), .i_v_left(v_left), .i_tb_en(tb_en1),
    .o_score(score1), .o_score_vld(vld1), .o_data(data1), .o_data_oe(oe1),
    .o_tb_diag(td1), .o_tb_up(tu1), .o_tb_left(tl1), .o_tb_done(tn1), .o_sat(sat1));

  dtw_score_cell #(.DW(DW), .IW(IW), .TINDEX(5'd31), .RINDEX(5'd31)) u_unused (
    .clk(clk), .rst(rst), .i_clr(clr), .i_valid(valid), .i_tindex(tidx), .i_rindex(ridx),
    .i_dlocal(dlocal), .i_s_diag(s_diag), .i_s_up(s_up), .i_s_left(s_left),
    .i_v_diag(v_diag), .i_v_up(v_up), .i_v_left(v_left), .i_tb_en(tb_en2),
    .o_score(score2), .o_score_vld(vld2), .o_data(data2), .o_data_oe(oe2),
    .o_tb_diag(td2), .o_tb_up(tu2), .o_tb_left(tl2), .o_tb_done(tn2), .o_sat(sat2));

  obs_t obs0, obs1, obs2;
  assign obs0 = {data0, oe0, {td0, tu0, tl0, tn0}, score0, vld0, sat0};
  assign obs1 = {data1, oe1, {td1, tu1, tl1, tn1}, score1, vld1, sat1};
  assign obs2 = {data2, oe2, {td2, tu2, tl2, tn2}, score2, vld2, sat2};

  // Scoreboard queues (parallel, one entry per expected observation).
  int    q_cyc[$];
  int    q_id[$];
  string q_tag[$];
  obs_t  q_exp[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  int    m_id;
  string m_tag;
  obs_t  m_exp;
  obs_t  m_act;

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      void'(q_cyc.pop_front());
      m_id  = q_id.pop_front();
      m_tag = q_tag.pop_front();
      m_exp = q_exp.pop_front();
      m_act = (m_id == 0) ? obs0 : ((m_id == 1) ? obs1 : obs2);
      checks = checks + 1;
      if (m_act !== m_exp) begin
        failures = failures + 1;
        $display("FAIL %s cell%0d: got data=%h oe=%b pulse=%b score=%h vld=%b sat=%b, required data=%h oe=%b pulse=%b score=%h vld=%b sat=%b",
                 m_tag, m_id, m_act.data, m_act.oe, m_act.pul, m_act.score, m_act.vld, m_act.sat,
                 m_exp.data, m_exp.oe, m_exp.pul, m_exp.score, m_exp.vld, m_exp.sat);
      end
    end
  end

  function automatic logic [XW-1:0] mk(input logic [1:0] p, input logic [IW-1:0] t,
                                       input logic [IW-1:0] r, input logic [DW-1:0] s);
    mk = {p, t, r, s};
  endfunction

  task automatic push(input int id, input string tag, input logic [XW-1:0] d, input logic oe,
                      input logic [3:0] p, input logic [DW-1:0] sc, input logic vld, input logic sat);
    obs_t e;
    e = {d, oe, p, sc, vld, sat};
    q_cyc.push_back(cyc);
    q_id.push_back(id);
    q_tag.push_back(tag);
    q_exp.push_back(e);
  endtask

  task automatic idle();
    rst = 1'b0; clr = 1'b0; valid = 1'b0;
    tidx = 5'd0; ridx = 5'd0; dlocal = 16'd0;
    s_diag = 16'd0; s_up = 16'd0; s_left = 16'd0;
    v_diag = 1'b0; v_up = 1'b0; v_left = 1'b0;
    tb_en0 = 1'b0; tb_en1 = 1'b0; tb_en2 = 1'b0;
  endtask

  task automatic cap(input logic [IW-1:0] t, input logic [IW-1:0] r, input logic [DW-1:0] dl,
                     input logic vd, input logic vu, input logic vl,
                     input logic [DW-1:0] sd, input logic [DW-1:0] su, input logic [DW-1:0] sl);
    valid = 1'b1; tidx = t; ridx = r; dlocal = dl;
    v_diag = vd; v_up = vu; v_left = vl;
    s_diag = sd; s_up = su; s_left = sl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [XW-1:0] Z = '0;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    // reset state on all three cells
    idle();
    push(0, "reset_origin", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    push(1, "reset_cell32", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    push(2, "reset_unused", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    // origin capture with traceback in the same cycle (ignored while empty)
    idle(); cap(5'd0, 5'd0, 16'd7, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0); tb_en0 = 1'b1;
    push(0, "empty_tb_ignored", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle(); tb_en0 = 1'b1;
    push(0, "origin_drive", mk(2'b00, 5'd0, 5'd0, 16'd7), 1'b1, 4'b0000, 16'd7, 1'b1, 1'b0);
    push(1, "index_mismatch", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle();
    push(0, "origin_done_pulse", Z, 1'b0, 4'b0001, 16'd7, 1'b1, 1'b0);
    tick();
    idle(); tb_en0 = 1'b1;
    push(0, "traced_drive", mk(2'b00, 5'd0, 5'd0, 16'd7), 1'b1, 4'b0000, 16'd7, 1'b1, 1'b0);
    tick();
    idle();
    push(0, "traced_no_pulse", Z, 1'b0, 4'b0000, 16'd7, 1'b1, 1'b0);
    tick();
    // cell (3,2): diag=10 up=8 left=8 dlocal=5 -> 13 via up
    idle(); cap(5'd3, 5'd2, 16'd5, 1'b1, 1'b1, 1'b1, 16'd10, 16'd8, 16'd8);
    push(1, "pre_capture", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle(); tb_en1 = 1'b1;
    push(1, "tie_up_drive", mk(2'b10, 5'd3, 5'd2, 16'd13), 1'b1, 4'b0000, 16'd13, 1'b1, 1'b0);
    tick();
    idle(); tb_en1 = 1'b1;
    push(1, "up_pulse", mk(2'b10, 5'd3, 5'd2, 16'd13), 1'b1, 4'b0100, 16'd13, 1'b1, 1'b0);
    tick();
    idle(); tb_en1 = 1'b1;
    push(1, "hold_no_pulse1", mk(2'b10, 5'd3, 5'd2, 16'd13), 1'b1, 4'b0000, 16'd13, 1'b1, 1'b0);
    tick();
    idle(); tb_en1 = 1'b1;
    push(1, "hold_no_pulse2", mk(2'b10, 5'd3, 5'd2, 16'd13), 1'b1, 4'b0000, 16'd13, 1'b1, 1'b0);
    tick();
    // second capture attempt with dlocal=1 must be ignored
    idle(); cap(5'd3, 5'd2, 16'd1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    push(1, "hold_released", Z, 1'b0, 4'b0000, 16'd13, 1'b1, 1'b0);
    tick();
    idle(); clr = 1'b1;
    push(1, "second_capture_ignored", Z, 1'b0, 4'b0000, 16'd13, 1'b1, 1'b0);
    tick();
    // re-capture after clear: only left valid, 4+1 -> 5 via left
    idle(); cap(5'd3, 5'd2, 16'd1, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 16'd4);
    push(1, "clear_cell32", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    push(0, "clear_origin", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle(); tb_en1 = 1'b1;
    push(1, "recapture_left", mk(2'b01, 5'd3, 5'd2, 16'd5), 1'b1, 4'b0000, 16'd5, 1'b1, 1'b0);
    tick();
    idle(); clr = 1'b1;
    push(1, "left_pulse", Z, 1'b0, 4'b0010, 16'd5, 1'b1, 1'b0);
    tick();
    // saturation: only up valid, FFF0 + 0020 overflows; invalid diag=0 ignored
    idle(); cap(5'd3, 5'd2, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFF0, 16'h0000);
    push(1, "cleared_before_sat", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle(); tb_en1 = 1'b1;
    push(1, "sat_capture", mk(2'b10, 5'd3, 5'd2, 16'hFFFF), 1'b1, 4'b0000, 16'hFFFF, 1'b1, 1'b1);
    tick();
    idle();
    push(1, "sat_up_pulse", Z, 1'b0, 4'b0100, 16'hFFFF, 1'b1, 1'b1);
    tick();
    idle(); clr = 1'b1;
    push(1, "sat_sticky", Z, 1'b0, 4'b0000, 16'hFFFF, 1'b1, 1'b1);
    tick();
    // three-way tie at 4, dlocal=2 -> 6 via diag
    idle(); cap(5'd3, 5'd2, 16'd2, 1'b1, 1'b1, 1'b1, 16'd4, 16'd4, 16'd4);
    push(1, "sat_cleared", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle(); tb_en1 = 1'b1;
    push(1, "tie_diag_drive", mk(2'b11, 5'd3, 5'd2, 16'd6), 1'b1, 4'b0000, 16'd6, 1'b1, 1'b0);
    tick();
    // origin recapture, then reset together with traceback
    idle(); cap(5'd0, 5'd0, 16'd9, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    push(1, "diag_pulse", Z, 1'b0, 4'b1000, 16'd6, 1'b1, 1'b0);
    tick();
    idle(); rst = 1'b1; tb_en0 = 1'b1;
    push(0, "pre_reset_drive", mk(2'b00, 5'd0, 5'd0, 16'd9), 1'b1, 4'b0000, 16'd9, 1'b1, 1'b0);
    tick();
    // unused cell: capture and traceback at (31,31) together
    idle(); cap(5'd31, 5'd31, 16'd3, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0); tb_en2 = 1'b1;
    push(0, "reset_no_pulse", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    push(1, "reset_cell32_mid", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    push(2, "unused_no_capture", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle(); tb_en2 = 1'b1;
    push(2, "unused_tb_no_drive", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    idle();
    push(2, "unused_no_pulse", Z, 1'b0, 4'b0000, 16'd0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    #1;
    if (q_cyc.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", q_cyc.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
